// File: rtl/decryption_defs.sv
// Shared definitions for the decryptor blocks: token default, mode encodings
// and the key-slice extraction helper.
package decryption_defs;

  localparam logic [7:0] TOKEN_DEFAULT = 8'hFA;

  typedef enum logic {
    MODE_CAESAR   = 1'b0,
    MODE_VIGENERE = 1'b1
  } mode_e;

  // Upper bounds for the flattened key and a single slice accepted by key_slice.
  localparam int KEY_BITS_MAX = 512;
  localparam int DW_MAX       = 64;

  // Returns slice idx (each 'width' bits wide) of a flattened key, zero-extended.
  function automatic logic [DW_MAX-1:0] key_slice(input logic [KEY_BITS_MAX-1:0] key_flat,
                                                  input int unsigned            idx,
                                                  input int unsigned            width);
    logic [KEY_BITS_MAX-1:0] shifted;
    logic [DW_MAX-1:0]       mask;
    shifted = key_flat >> (idx * width);
    mask    = ~({DW_MAX{1'b1}} << width);
    return DW_MAX'(shifted) & mask;
  endfunction

endpackage

// File: rtl/decrypt_fifo.sv
// Synchronous show-ahead FIFO; the head word is always visible on data.
// Full and empty are decoded from the occupancy count, not pointer equality.
module decrypt_fifo #(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [D_WIDTH-1:0]            push_data,
  input  logic                          pop,
  output logic [D_WIDTH-1:0]            data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = mem[rd_ptr];

  // NOTE: storage has no reset; valid data is tracked by count, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_decryption.sv
// Caesar / Vigenere shift decryptor with a backpressured output FIFO.
// Results are registered in the FIFO; nothing on data_o depends on data_i combinationally.
module shift_decryption
  import decryption_defs::*;
#(
  parameter int                 D_WIDTH    = 8,
  parameter int                 KEY_NUM    = 4,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [D_WIDTH-1:0] TOKEN      = D_WIDTH'(TOKEN_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [D_WIDTH-1:0]         data_i,
  input  logic                       valid_i,
  input  logic                       mode,
  input  logic [KEY_NUM*D_WIDTH-1:0] key,
  input  logic                       ready_i,
  output logic                       busy,
  output logic [D_WIDTH-1:0]         data_o,
  output logic                       valid_o,
  output logic                       overflow
);

  localparam int KIDX_W = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

  logic [KIDX_W-1:0]         kidx;
  logic [KIDX_W-1:0]         slice_idx;
  logic [D_WIDTH-1:0]        sel_key;
  logic [D_WIDTH-1:0]        result;
  logic                      accept;
  logic                      is_token;
  mode_e                     word_mode;
  logic [D_WIDTH-1:0]        fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign word_mode = mode_e'(mode);
  assign accept    = valid_i && !busy;
  assign is_token  = (data_i == TOKEN);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    slice_idx = '0;
    if (word_mode == MODE_VIGENERE) slice_idx = kidx;
    sel_key = D_WIDTH'(key_slice(KEY_BITS_MAX'(key), 32'(slice_idx), D_WIDTH));
    result  = is_token ? data_i : data_i - sel_key;
  end

  // The key index only moves on accepted words; dropped words leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kidx <= '0;
    end else if (accept) begin
      if (is_token) begin
        kidx <= '0;
      end else if (word_mode == MODE_VIGENERE) begin
        if (kidx == KIDX_W'(KEY_NUM - 1)) kidx <= '0;
        else                              kidx <= kidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               overflow <= 1'b0;
    else if (valid_i && busy) overflow <= 1'b1;
  end

  decrypt_fifo #(
    .D_WIDTH    (D_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (result),
    .pop       (ready_i),
    .data      (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy    = fifo_full;
  assign valid_o = (fifo_count != '0);
  assign data_o  = fifo_empty ? '0 : fifo_data;

endmodule

// File: tb/tb_shift_decryption.sv
// Directed bench for shift_decryption: the driver queues hand-computed results,
// a negedge monitor pops and compares them whenever the DUT hands a word over.
module tb_shift_decryption;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        mode;
  logic [31:0] key;
  logic        ready_i;
  logic        busy;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        overflow;

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  shift_decryption dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .mode     (mode),
    .key      (key),
    .ready_i  (ready_i),
    .busy     (busy),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handover is valid_o && ready_i, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no word (t=%0t)", data_o, $time);
        end else begin
          check("scoreboard", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
        end
      end
      if (!valid_o) check("data_o_idle_zero", {24'h0, data_o}, 32'h0);
    end
  end

  task automatic send(input logic [7:0] d, input logic acc, input logic [7:0] exp);
    data_i  = d;
    valid_i = 1'b1;
    if (acc) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("drain_complete", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    mode    = 1'b0;
    key     = 32'h0000_0003;
    ready_i = 1'b1;
    #2;
    check("reset_busy",     {31'h0, busy},     32'h0);
    check("reset_valid_o",  {31'h0, valid_o},  32'h0);
    check("reset_data_o",   {24'h0, data_o},   32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: Caesar, slice 0 = 03; one-cycle latency and subtraction wrap.
    data_i  = 8'h44;
    valid_i = 1'b1;
    exp_q.push_back(8'h41);
    @(posedge clk);
    #1;
    data_i = 8'h02;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    check("t1_valid_first", {31'h0, valid_o}, 32'h1);
    check("t1_data_first",  {24'h0, data_o},  32'h41);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("t1_valid_second", {31'h0, valid_o}, 32'h1);
    check("t1_data_second",  {24'h0, data_o},  32'hFF);
    @(negedge clk);
    check("t1_valid_done", {31'h0, valid_o}, 32'h0);
    wait_drain();

    // Test 2: Vigenere with slices {04,03,02,01}; index wraps after slice 3.
    mode = 1'b1;
    key  = 32'h0403_0201;
    send(8'h10, 1'b1, 8'h0F);
    send(8'h10, 1'b1, 8'h0E);
    send(8'h10, 1'b1, 8'h0D);
    send(8'h10, 1'b1, 8'h0C);
    send(8'h10, 1'b1, 8'h0F);
    wait_drain();

    // Test 3: TOKEN passes through unmodified and restarts the key index.
    do_reset();
    mode = 1'b1;
    send(8'h10, 1'b1, 8'h0F);
    send(8'h10, 1'b1, 8'h0E);
    send(8'hFA, 1'b1, 8'hFA);
    send(8'h10, 1'b1, 8'h0F);
    wait_drain();

    // Test 4: fill with ready_i low, fifth word dropped, then drain.
    mode    = 1'b0;
    key     = 32'h0000_0003;
    ready_i = 1'b0;
    send(8'h20, 1'b1, 8'h1D);
    send(8'h21, 1'b1, 8'h1E);
    send(8'h22, 1'b1, 8'h1F);
    check("t4_busy_not_yet", {31'h0, busy}, 32'h0);
    send(8'h23, 1'b1, 8'h20);
    check("t4_busy_full", {31'h0, busy}, 32'h1);
    send(8'h24, 1'b0, 8'h00);
    check("t4_overflow_set", {31'h0, overflow}, 32'h1);
    check("t4_busy_held",    {31'h0, busy},     32'h1);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("t4_busy_falls", {31'h0, busy}, 32'h0);
    wait_drain();
    check("t4_overflow_sticky", {31'h0, overflow}, 32'h1);

    // Test 5: hold occupancy at 2 with simultaneous push and pop.
    ready_i = 1'b0;
    send(8'h30, 1'b1, 8'h2D);
    send(8'h31, 1'b1, 8'h2E);
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'h32 + 8'(i), 1'b1, 8'h2F + 8'(i));
      check("t5_count_steady", 32'(dut.u_fifo.count), 32'h2);
      check("t5_busy_low",     {31'h0, busy},         32'h0);
    end
    wait_drain();

    // Test 6: asynchronous reset with 3 words buffered and key index at 2.
    mode    = 1'b1;
    key     = 32'h0403_0201;
    ready_i = 1'b0;
    send(8'hFA, 1'b1, 8'hFA);
    send(8'h10, 1'b1, 8'h0F);
    send(8'h10, 1'b1, 8'h0E);
    check("t6_valid_before", {31'h0, valid_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid_o",  {31'h0, valid_o},  32'h0);
    check("t6_async_data_o",   {24'h0, data_o},   32'h0);
    check("t6_async_busy",     {31'h0, busy},     32'h0);
    check("t6_async_overflow", {31'h0, overflow}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    send(8'h10, 1'b1, 8'h0F);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_decryption.md
# shift_decryption

Parametrised successor to the single-key shift decryptor. It decrypts a byte stream with either one fixed shift (Caesar mode) or a rotating multi-shift key (Vigenère mode), and buffers results in an output FIFO so the downstream consumer can apply backpressure. It sits between the decryption demultiplexer and the output multiplexer in the decryption top level.

## Interface
Parameters:
- D_WIDTH, 8, data word width in bits.
- KEY_NUM, 4, number of D_WIDTH key slices available in Vigenère mode; must be ≥1.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, ≥2.
- TOKEN, 8'hFA, message-end token value; sized to D_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_i  in  D_WIDTH  encrypted word.
- valid_i  in  1  data_i is valid this cycle.
- mode  in  1  0 = Caesar, 1 = Vigenère; sampled with every accepted word.
- key  in  KEY_NUM*D_WIDTH  slice k is key[(k+1)*D_WIDTH-1 : k*D_WIDTH]; sampled with every accepted word.
- ready_i  in  1  downstream accepts data_o this cycle.
- busy  out  1  FIFO full; upstream must not assert valid_i.
- data_o  out  D_WIDTH  decrypted word at the FIFO head.
- valid_o  out  1  data_o is valid.
- overflow  out  1  sticky flag; set when a word arrives while busy.

## Operation
- Accept: valid_i && !busy.
- The key index kidx has $clog2(KEY_NUM) bits, or 1 bit when KEY_NUM=1. It resets to 0.
- Caesar mode, accepted word: result = data_i − slice 0, modulo 2^D_WIDTH. kidx is unchanged.
- Vigenère mode, accepted word: result = data_i − slice kidx, modulo 2^D_WIDTH.
  - kidx then advances by 1 and wraps from KEY_NUM−1 to 0.
- TOKEN handling, both modes: an accepted word equal to TOKEN is pushed unmodified and kidx is cleared to 0.
- Mode and key may change between words. Each word uses the mode, key and kidx values present at its acceptance.
- Pop: valid_o && ready_i. The FIFO head advances.
- Simultaneous push and pop are allowed whenever !busy. The occupancy count is unchanged.
- Word arriving while busy:
  - The word is dropped and kidx is not advanced.
  - overflow sets and stays set until reset.
  - A pop in the same cycle does not rescue the word, because busy reflects the registered full state.
- There are no other states. The control is the FIFO occupancy counter (0..FIFO_DEPTH) plus kidx.

## Timing
Reset values (asynchronous, immediate on rst_n low):
- busy=0, valid_o=0, data_o=0, overflow=0.
- FIFO pointers and count = 0, kidx = 0.

Latency and flags:
- Latency: a word accepted at edge N is visible on data_o/valid_o after edge N, when the FIFO is empty. This is one cycle, matching the previous generation.
- data_o and valid_o come from registers only (show-ahead FIFO head). There is no combinational path from data_i.
- data_o is 0 whenever valid_o=0. FIFO storage itself is not reset-cleared.
- busy = (count == FIFO_DEPTH), from registers. It rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop from full.
- valid_o = (count != 0).
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.

Reset mid-operation:
- All buffered words are discarded.
- valid_o falls immediately.
- The first word accepted after reset release uses kidx=0.

## Structure
- Shared package/header decryption_defs: TOKEN default, mode encodings (MODE_CAESAR=0, MODE_VIGENERE=1), and the key-slice extraction helper. These are also used by the other decryptor blocks.
- Sub-module decrypt_fifo: synchronous show-ahead FIFO with parameters D_WIDTH and FIFO_DEPTH.
  - Ports: push, push_data, pop, data, count, full, empty.
  - Same clock and asynchronous active-low reset as the parent.
- Top module shift_decryption contains: accept logic, subtractor, slice multiplexer, kidx counter, overflow flag, and the decrypt_fifo instance.

## Test plan
1. Caesar, defaults, key slice 0 = 8'h03, ready_i=1. Send 8'h44 then 8'h02. Expect data_o 8'h41, then 8'hFF (wrap), each 1 cycle after acceptance, with valid_o high for exactly those 2 cycles.
2. Vigenère, slices {3,2,1,0} = {04,03,02,01}. Send 5×8'h10. Expect 0F, 0E, 0D, 0C, 0F (kidx wraps).
3. Vigenère, same key. Send 10, 10, FA, 10. Expect 0F, 0E, FA, 0F (TOKEN passes through unmodified and clears kidx).
4. ready_i=0, FIFO_DEPTH=4. Send 5 words on consecutive cycles.
   - busy rises after the 4th push; the 5th word is dropped and overflow=1.
   - Raise ready_i: the first 4 results drain in order and busy falls 1 cycle after the first pop.
5. Count=2 with ready_i=1. Push and pop simultaneously for 6 cycles. Expect count to stay at 2, busy=0, output order preserved.
6. Assert rst_n=0 mid-stream with 3 words buffered and kidx=2.
   - Outputs go to reset values immediately, without waiting for clk.
   - After release, 8'h10 in Vigenère mode decrypts with slice 0.
